// File: rtl/fp16_add_arbiter.sv
// Round-robin arbiter sharing one pipelined fp16 adder among NUM_REQ requesters,
// with a credit-guarded in-order result FIFO. Define FP16_ADD_ARB_STATS_EN for issue/stall counters.

module fp16_add #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_sum
);

  logic [15:0] r_pipe [LAT];

  function automatic logic [15:0] fp16_round(input logic sign, input logic [5:0] exp,
                                             input logic [13:0] sig);
    logic [4:0]  ef;
    logic        up;
    logic [14:0] mag;
    if (exp >= 6'd31) return {sign, 5'h1F, 10'h000};
    ef  = sig[13] ? exp[4:0] : 5'd0;
    up  = sig[2] & (sig[1] | sig[0] | sig[3]);
    // A mantissa carry ripples into the exponent field, covering subnormal->normal and ->Inf.
    mag = {ef, sig[12:3]} + {14'd0, up};
    return {sign, mag};
  endfunction

  function automatic logic [15:0] fp16_sum(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] big, sml;
    logic [5:0]  e_big, e_sml, d, e;
    logic [13:0] x_big, x_sml;
    logic [14:0] s;
    logic        lost, a_nan, b_nan, a_inf, b_inf;
    a_nan = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
    b_nan = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
    a_inf = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
    b_inf = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
    if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15]))) return 16'h7C01;
    if (a_inf) return a;
    if (b_inf) return b;
    if (a[14:0] >= b[14:0]) begin
      big = a; sml = b;
    end else begin
      big = b; sml = a;
    end
    e_big = (big[14:10] == 5'd0) ? 6'd1 : {1'b0, big[14:10]};
    e_sml = (sml[14:10] == 5'd0) ? 6'd1 : {1'b0, sml[14:10]};
    x_big = {big[14:10] != 5'd0, big[9:0], 3'b000};
    x_sml = {sml[14:10] != 5'd0, sml[9:0], 3'b000};
    d     = e_big - e_sml;
    for (int i = 0; i < 14; i++) begin
      if (6'(i) < d) begin
        lost     = x_sml[0];
        x_sml    = x_sml >> 1;
        x_sml[0] = x_sml[0] | lost;
      end
    end
    if (big[15] == sml[15]) s = {1'b0, x_big} + {1'b0, x_sml};
    else                    s = {1'b0, x_big} - {1'b0, x_sml};
    if (s == 15'd0) return (big[15] == sml[15]) ? {big[15], 15'd0} : 16'h0000;
    e = e_big;
    if (s[14]) begin
      s = {1'b0, s[14:2], s[1] | s[0]};
      e = e + 6'd1;
    end
    for (int i = 0; i < 13; i++) begin
      if (!s[13] && (e > 6'd1)) begin
        s = s << 1;
        e = e - 6'd1;
      end
    end
    return fp16_round(big[15], e, s[13:0]);
  endfunction

  // Stage boundary: operands captured and summed, then delayed to LAT edges total
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) r_pipe[i] <= 16'h0000;
    end else begin
      r_pipe[0] <= fp16_sum(i_a, i_b);
      for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_sum = r_pipe[LAT-1];

endmodule

module fp16_add_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ADD_LAT    = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [16*NUM_REQ-1:0]      req_a,
  input  logic [16*NUM_REQ-1:0]      req_b,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [15:0]                resp_result,
  output logic [$clog2(NUM_REQ)-1:0] resp_id
`ifdef FP16_ADD_ARB_STATS_EN
  ,
  output logic [15:0]                stat_issue_cnt,
  output logic [15:0]                stat_stall_cnt
`endif
);

  localparam int IDW  = $clog2(NUM_REQ);
  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam int CNTW = PTRW + 1;
  localparam int SUMW = $clog2(FIFO_DEPTH + ADD_LAT + 1) + 1;
  localparam logic [IDW:0]    NREQ_W  = (IDW+1)'(NUM_REQ);
  localparam logic [SUMW-1:0] DEPTH_W = SUMW'(FIFO_DEPTH);

  logic [IDW-1:0]    r_rr_ptr;
  logic [ADD_LAT-1:0] r_tag_vld;
  logic [IDW-1:0]    r_tag_id [ADD_LAT];
  logic [CNTW-1:0]   r_fifo_cnt;
  logic [PTRW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [IDW+15:0]   r_fifo_mem [FIFO_DEPTH];

  logic [IDW:0]      w_idx;
  logic              w_gnt_vld;
  logic [IDW-1:0]    w_gnt_id;
  logic [SUMW-1:0]   w_occ;
  logic              w_credit_ok, w_acc, w_push, w_pop;
  logic [15:0]       w_op_a, w_op_b, w_sum;
  logic [IDW+15:0]   w_head;

  // Round-robin search begins just past the last accepted requester.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    w_idx     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      if (w_idx >= NREQ_W) w_idx = w_idx - NREQ_W;
      if (!w_gnt_vld && req_valid[w_idx[IDW-1:0]]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = w_idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    w_occ = SUMW'(r_fifo_cnt);
    for (int i = 0; i < ADD_LAT; i++) w_occ = w_occ + SUMW'(r_tag_vld[i]);
  end

  assign w_credit_ok = (w_occ < DEPTH_W);
  assign w_acc       = w_gnt_vld & w_credit_ok & rst_n;
  assign req_ready   = w_acc ? (NUM_REQ'(1) << w_gnt_id) : '0;
  assign w_op_a      = w_gnt_vld ? req_a[{w_gnt_id, 4'b0000} +: 16] : 16'h0000;
  assign w_op_b      = w_gnt_vld ? req_b[{w_gnt_id, 4'b0000} +: 16] : 16'h0000;
  assign w_push      = r_tag_vld[ADD_LAT-1];
  assign w_pop       = (r_fifo_cnt != '0) & resp_ready;

  fp16_add #(.LAT(ADD_LAT)) u_add (
    .clk   (clk),
    .rst_n (rst_n),
    .i_a   (w_op_a),
    .i_b   (w_op_b),
    .o_sum (w_sum)
  );

  // Stage boundary: tag pipeline tracks each accepted operand pair through the adder
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_vld  <= '0;
      r_rr_ptr   <= IDW'(NUM_REQ - 1);
      r_fifo_cnt <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_tag_vld[0] <= w_acc;
      for (int i = 1; i < ADD_LAT; i++) r_tag_vld[i] <= r_tag_vld[i-1];
      if (w_acc)  r_rr_ptr <= w_gnt_id;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTRW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTRW'(1);
      r_fifo_cnt <= r_fifo_cnt + CNTW'(w_push) - CNTW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    r_tag_id[0] <= w_gnt_id;
    for (int i = 1; i < ADD_LAT; i++) r_tag_id[i] <= r_tag_id[i-1];
    if (w_push) r_fifo_mem[r_wr_ptr] <= {r_tag_id[ADD_LAT-1], w_sum};
  end

  assign w_head      = r_fifo_mem[r_rd_ptr];
  assign resp_valid  = (r_fifo_cnt != '0);
  assign resp_result = resp_valid ? w_head[15:0] : 16'h0000;
  assign resp_id     = resp_valid ? w_head[IDW+15:16] : '0;

`ifdef FP16_ADD_ARB_STATS_EN
  logic [15:0] r_issue_cnt, r_stall_cnt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issue_cnt <= 16'd0;
      r_stall_cnt <= 16'd0;
    end else begin
      if (w_acc)                       r_issue_cnt <= sat_inc(r_issue_cnt);
      if ((|req_valid) && !w_credit_ok) r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  assign stat_issue_cnt = r_issue_cnt;
  assign stat_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fp16_add_arbiter.sv
// Directed bench for fp16_add_arbiter: grant order, latency, credit back-pressure,
// special values and mid-operation reset, with hand-computed sums.

module tb_fp16_add_arbiter;

  localparam int NR = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid, req_ready;
  logic [16*NR-1:0]  req_a, req_b;
  logic              resp_valid, resp_ready;
  logic [15:0]       resp_result;
  logic [1:0]        resp_id;
`ifdef FP16_ADD_ARB_STATS_EN
  logic [15:0]       stat_issue_cnt, stat_stall_cnt;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  int          n_resp = 0;
  int          n0;
  logic [NR-1:0] last_gnt;
  logic [17:0] expq [$];
  logic [15:0] exp_sum [NR];

  always #5 clk = ~clk;

  fp16_add_arbiter #(.NUM_REQ(NR), .FIFO_DEPTH(4), .ADD_LAT(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_id     (resp_id)
`ifdef FP16_ADD_ARB_STATS_EN
    ,
    .stat_issue_cnt (stat_issue_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_op(input int id, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] s);
    req_a[id*16 +: 16] = a;
    req_b[id*16 +: 16] = b;
    exp_sum[id] = s;
  endtask

  // Samples the handshakes that the coming rising edge will complete, then moves to the next falling edge.
  task automatic tick();
    logic [17:0] e;
    #1;
    last_gnt = req_ready;
    for (int i = 0; i < NR; i++)
      if (req_valid[i] && req_ready[i]) expq.push_back({2'(i), exp_sum[i]});
    if (resp_valid && resp_ready) begin
      if (expq.size() == 0) begin
        chk_eq("resp_unexpected", 32'(expq.size()), 32'd1);
      end else begin
        e = expq.pop_front();
        chk_eq("resp", {14'd0, resp_id, resp_result}, {14'd0, e});
      end
      n_resp++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    resp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    expq.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    resp_ready = 1'b0;
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NR; i++) exp_sum[i] = 16'h0000;
    @(negedge clk);
    req_valid = '1;
    #1;
    chk_eq("rst_req_ready", 32'(req_ready), 32'd0);
    chk_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk_eq("rst_resp_result", 32'(resp_result), 32'd0);
    chk_eq("rst_resp_id", 32'(resp_id), 32'd0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // 1.0 + 1.0 with latency check
    set_op(0, 16'h3C00, 16'h3C00, 16'h4000);
    req_valid = 4'b0001;
    resp_ready = 1'b1;
    tick();
    chk_eq("lat_gnt", 32'(last_gnt), 32'd1);
    req_valid = '0;
    chk_eq("lat_c1_valid", 32'(resp_valid), 32'd0);
    tick();
    chk_eq("lat_c2_valid", 32'(resp_valid), 32'd0);
    tick();
    chk_eq("lat_c3_valid", 32'(resp_valid), 32'd1);
    chk_eq("lat_c3_result", 32'(resp_result), 32'h4000);
    chk_eq("lat_c3_id", 32'(resp_id), 32'd0);
    tick();
    chk_eq("lat_pop_valid", 32'(resp_valid), 32'd0);
    chk_eq("lat_resp_cnt", 32'(n_resp), 32'd1);

    // All requesters valid: strict rotation, one accept per cycle
    do_reset();
    set_op(0, 16'h3C00, 16'h3C00, 16'h4000);
    set_op(1, 16'h3C00, 16'h4000, 16'h4200);
    set_op(2, 16'h3C00, 16'h4200, 16'h4400);
    set_op(3, 16'h3C00, 16'h4400, 16'h4500);
    resp_ready = 1'b1;
    req_valid = 4'b1111;
    n0 = n_resp;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk_eq($sformatf("rr_gnt%0d", k), 32'(last_gnt), 32'd1 << (k % 4));
    end
    req_valid = '0;
    for (int k = 0; k < 6; k++) tick();
    chk_eq("rr_resp_cnt", 32'(n_resp - n0), 32'd8);
    chk_eq("rr_q_empty", 32'(expq.size()), 32'd0);

    // Back-pressure: consumer stalled, requester 1 streams
    do_reset();
    set_op(1, 16'h3C00, 16'h3C00, 16'h4000);
    resp_ready = 1'b0;
    req_valid = 4'b0010;
    n0 = n_resp;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk_eq($sformatf("bp_gnt%0d", k), 32'(last_gnt), (k < 4) ? 32'd2 : 32'd0);
    end
    chk_eq("bp_full_valid", 32'(resp_valid), 32'd1);
    chk_eq("bp_full_id", 32'(resp_id), 32'd1);
`ifdef FP16_ADD_ARB_STATS_EN
    chk_eq("bp_stall_cnt", 32'(stat_stall_cnt), 32'd6);
    chk_eq("bp_issue_cnt", 32'(stat_issue_cnt), 32'd4);
`endif

    // Full FIFO, single-cycle pops: each pop frees exactly one accept
    for (int r = 0; r < 4; r++) begin
      resp_ready = 1'b1;
      tick();
      chk_eq($sformatf("tog%0d_pop_gnt", r), 32'(last_gnt), 32'd0);
      resp_ready = 1'b0;
      tick();
      chk_eq($sformatf("tog%0d_acc_gnt", r), 32'(last_gnt), 32'd2);
      tick();
      chk_eq($sformatf("tog%0d_hold_gnt", r), 32'(last_gnt), 32'd0);
    end
    req_valid = '0;
    resp_ready = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    chk_eq("tog_resp_cnt", 32'(n_resp - n0), 32'd8);
    chk_eq("tog_q_empty", 32'(expq.size()), 32'd0);

    // Special values, subnormals and overflow
    do_reset();
    set_op(0, 16'h0001, 16'h0001, 16'h0002);
    set_op(1, 16'h7BFF, 16'h7BFF, 16'h7C00);
    set_op(2, 16'h7C00, 16'hFC00, 16'h7C01);
    set_op(3, 16'h3C00, 16'hBC00, 16'h0000);
    resp_ready = 1'b1;
    req_valid = 4'b1100;
    n0 = n_resp;
    tick();
    chk_eq("sp_gnt2", 32'(last_gnt), 32'd4);
    tick();
    chk_eq("sp_gnt3", 32'(last_gnt), 32'd8);
    req_valid = 4'b0011;
    tick();
    tick();
    req_valid = '0;
    for (int k = 0; k < 6; k++) tick();
    chk_eq("sp_resp_cnt", 32'(n_resp - n0), 32'd4);

    // Reset with two in flight and two buffered
    do_reset();
    set_op(0, 16'h4000, 16'h4000, 16'h4400);
    resp_ready = 1'b0;
    req_valid = 4'b0001;
    for (int k = 0; k < 4; k++) tick();
    chk_eq("mr_pre_valid", 32'(resp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_eq("mr_resp_valid", 32'(resp_valid), 32'd0);
    chk_eq("mr_req_ready", 32'(req_ready), 32'd0);
    chk_eq("mr_resp_result", 32'(resp_result), 32'd0);
    expq.delete();
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    set_op(1, 16'h3C00, 16'h3C00, 16'h4000);
    req_valid = 4'b0011;
    resp_ready = 1'b1;
    n0 = n_resp;
    tick();
    chk_eq("mr_first_gnt", 32'(last_gnt), 32'd1);
    req_valid = '0;
    for (int k = 0; k < 6; k++) tick();
    chk_eq("mr_resp_cnt", 32'(n_resp - n0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
